// File: rtl/div_regs.sv
// Register map, init value and FSM state encoding shared between the divider
// peripheral and its bus master.
package div_regs;

  localparam logic [4:0]  REG_OP_A   = 5'h04;
  localparam logic [4:0]  REG_OP_B   = 5'h08;
  localparam logic [4:0]  REG_INIT   = 5'h0C;
  localparam logic [4:0]  REG_RESULT = 5'h10;
  localparam logic [4:0]  REG_DONE   = 5'h14;
  localparam logic [15:0] INIT_VALUE = 16'h0001;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_A      = 4'd1,
    ST_WR_B      = 4'd2,
    ST_WR_INIT   = 4'd3,
    ST_POLL      = 4'd4,
    ST_POLL_WAIT = 4'd5,
    ST_RD        = 4'd6,
    ST_RD_WAIT   = 4'd7,
    ST_RESP      = 4'd8,
    ST_GAP       = 4'd9
  } div_state_e;

  // Register address driven while a bus-access state is active; 0 otherwise.
  function automatic logic [4:0] state_addr(input div_state_e s);
    logic [4:0] a;
    case (s)
      ST_WR_A:    a = REG_OP_A;
      ST_WR_B:    a = REG_OP_B;
      ST_WR_INIT: a = REG_INIT;
      ST_POLL:    a = REG_DONE;
      ST_RD:      a = REG_RESULT;
      default:    a = 5'h00;
    endcase
    return a;
  endfunction

  function automatic logic is_write_state(input div_state_e s);
    return (s == ST_WR_A) || (s == ST_WR_B) || (s == ST_WR_INIT);
  endfunction

  function automatic logic is_read_state(input div_state_e s);
    return (s == ST_POLL) || (s == ST_RD);
  endfunction

endpackage

// File: rtl/div_bus_master.sv
// Bus master for the divider peripheral: writes both operands, kicks off the
// division, polls the done flag and returns the raw result word.
module div_bus_master
  import div_regs::*;
#(
  parameter int POLL_MAX = 64,
  parameter int GAP      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [4:0]  addr,
  output logic [15:0] wdata,
  input  logic [31:0] rdata
);

  localparam int PCW = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(POLL_MAX);
  localparam logic [GCW-1:0] GAP_LOAD   = GCW'(GAP - 1);

  div_state_e     state_q, state_d;
  div_state_e     ret_q, ret_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [15:0]    op_a_q, op_a_d;
  logic [15:0]    op_b_q, op_b_d;
  logic [31:0]    resp_data_q, resp_data_d;
  logic           resp_err_q, resp_err_d;
  logic           resp_valid_q, resp_valid_d;
  logic           ready_q, ready_d;
  logic           cs_q, cs_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [4:0]     addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           via_gap_s;
  div_state_e     gap_tgt_s;

  // Next-state, counters, operand latches and response registers.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    gap_cnt_d   = gap_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    via_gap_s   = 1'b0;
    gap_tgt_s   = ST_IDLE;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_WR_A;
          op_a_d      = op_a;
          op_b_d      = op_b;
          poll_cnt_d  = '0;
          resp_data_d = 32'h0000_0000;
          resp_err_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_A: begin
        via_gap_s = 1'b1;
        gap_tgt_s = ST_WR_B;
      end
      ST_WR_B: begin
        via_gap_s = 1'b1;
        gap_tgt_s = ST_WR_INIT;
      end
      ST_WR_INIT: begin
        via_gap_s = 1'b1;
        gap_tgt_s = ST_POLL;
      end
      ST_POLL: begin
        state_d    = ST_POLL_WAIT;
        poll_cnt_d = poll_cnt_q + {{(PCW-1){1'b0}}, 1'b1};
      end
      ST_POLL_WAIT: begin
        // Timeout skips the result read and reports an error with zero data.
        if (rdata[0]) begin
          via_gap_s = 1'b1;
          gap_tgt_s = ST_RD;
        end else if (poll_cnt_q == POLL_LIMIT) begin
          state_d     = ST_RESP;
          resp_err_d  = 1'b1;
          resp_data_d = 32'h0000_0000;
        end else begin
          via_gap_s = 1'b1;
          gap_tgt_s = ST_POLL;
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d     = ST_RESP;
        resp_data_d = rdata;
        resp_err_d  = 1'b0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ret_q;
        end else begin
          gap_cnt_d = gap_cnt_q - {{(GCW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // GAP == 0 removes the idle state entirely.
    if (via_gap_s) begin
      if (GAP == 0) begin
        state_d = gap_tgt_s;
      end else begin
        state_d   = ST_GAP;
        ret_d     = gap_tgt_s;
        gap_cnt_d = GAP_LOAD;
      end
    end else begin
      ret_d = ret_q;
    end
  end

  // Bus and handshake outputs decoded from the next state so they register in step with it.
  always_comb begin
    cs_d         = 1'b0;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = 5'h00;
    wdata_d      = 16'h0000;
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    if (is_write_state(state_d) || is_read_state(state_d)) begin
      cs_d   = 1'b1;
      wr_d   = is_write_state(state_d);
      rd_d   = is_read_state(state_d);
      addr_d = state_addr(state_d);
    end else begin
      cs_d = 1'b0;
    end
    case (state_d)
      ST_WR_A:    wdata_d = op_a_d;
      ST_WR_B:    wdata_d = op_b_d;
      ST_WR_INIT: wdata_d = INIT_VALUE;
      default:    wdata_d = 16'h0000;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      gap_cnt_q    <= '0;
      poll_cnt_q   <= '0;
      op_a_q       <= 16'h0000;
      op_b_q       <= 16'h0000;
      resp_data_q  <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 5'h00;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      gap_cnt_q    <= gap_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign cs         = cs_q;
  assign rd         = rd_q;
  assign wr         = wr_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_div_bus_master.sv
// Self-checking bench for div_bus_master: a behavioural divider stub plus a
// scoreboard of expected bus accesses and responses.
module tb_div_bus_master;
  import div_regs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic [31:0] rdata = 32'h0000_0000;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic        req_ready0, resp_valid0, resp_err0, cs0, rd0, wr0;
  logic        req_ready1, resp_valid1, resp_err1, cs1, rd1, wr1;
  logic [31:0] resp_data0, resp_data1;
  logic [4:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;

  always #5 clk = ~clk;

  div_bus_master u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .op_a(op_a), .op_b(op_b), .resp_valid(resp_valid0), .resp_data(resp_data0),
    .resp_err(resp_err0), .cs(cs0), .rd(rd0), .wr(wr0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata)
  );

  div_bus_master #(.POLL_MAX(4), .GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .op_a(op_a), .op_b(op_b), .resp_valid(resp_valid1), .resp_data(resp_data1),
    .resp_err(resp_err1), .cs(cs1), .rd(rd1), .wr(wr1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata)
  );

  logic        sel = 1'b0;
  logic        m_cs, m_rd, m_wr, m_ready, m_resp_valid, m_resp_err;
  logic [4:0]  m_addr;
  logic [15:0] m_wdata;
  logic [31:0] m_resp_data;
  assign m_cs         = sel ? cs1 : cs0;
  assign m_rd         = sel ? rd1 : rd0;
  assign m_wr         = sel ? wr1 : wr0;
  assign m_addr       = sel ? addr1 : addr0;
  assign m_wdata      = sel ? wdata1 : wdata0;
  assign m_ready      = sel ? req_ready1 : req_ready0;
  assign m_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign m_resp_err   = sel ? resp_err1 : resp_err0;
  assign m_resp_data  = sel ? resp_data1 : resp_data0;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [32:0] resp_q[$];
  int checks = 0;
  int failures = 0;
  int poll_seen = 0;
  int done_target = 0;

  localparam logic [31:0] RESULT_WORD = 32'h0002_0002;

  // Divider stub: registered read data; done rises once the poll count reaches done_target.
  always @(posedge clk) begin
    if (m_cs && m_rd) begin
      if (m_addr == REG_DONE) begin
        rdata     <= {31'h2AD4_0000, (done_target != 0) && (poll_seen + 1 >= done_target)};
        poll_seen <= poll_seen + 1;
      end else begin
        rdata <= RESULT_WORD;
      end
    end
  end

  task automatic set_valid(input bit s, input logic v);
    if (s) req_valid1 = v;
    else   req_valid0 = v;
  endtask

  // One transaction: queue expectations, issue the request, score bus and response.
  task automatic run_txn(input string name, input bit s, input logic [15:0] a,
                         input logic [15:0] b, input int polls, input bit tmo,
                         input bit hold, input int pulse_at, input int exp_lat);
    bus_t        e;
    logic [32:0] exp_r;
    int          last_n;
    logic        last_rd;
    logic        prev_cs;
    bit          got;
    sel = s;
    done_target = tmo ? 0 : poll_seen + polls;
    bus_q.push_back('{wr: 1'b1, addr: REG_OP_A, data: a});
    bus_q.push_back('{wr: 1'b1, addr: REG_OP_B, data: b});
    bus_q.push_back('{wr: 1'b1, addr: REG_INIT, data: 16'h0001});
    for (int i = 0; i < polls; i++) bus_q.push_back('{wr: 1'b0, addr: REG_DONE, data: 16'h0000});
    if (!tmo) bus_q.push_back('{wr: 1'b0, addr: REG_RESULT, data: 16'h0000});
    resp_q.push_back(tmo ? {1'b1, 32'h0000_0000} : {1'b0, RESULT_WORD});

    @(negedge clk);
    op_a = a;
    op_b = b;
    set_valid(s, 1'b1);
    checks++;
    if (m_ready !== 1'b1) begin
      failures++;
      $display("FAIL %0s_ready_idle got=%b exp=1", name, m_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) set_valid(s, 1'b0);
    op_a = ~a;
    op_b = ~b;

    got = 1'b0;
    last_n = 0;
    last_rd = 1'b0;
    prev_cs = 1'b0;
    for (int n = 1; n <= 300 && !got; n++) begin
      @(negedge clk);
      if (pulse_at != 0 && n == pulse_at) set_valid(s, 1'b1);
      if (pulse_at != 0 && n == pulse_at + 1) set_valid(s, 1'b0);
      if (m_cs) begin
        checks++;
        if (prev_cs) begin
          failures++;
          $display("FAIL %0s_cs_consecutive n=%0d got cs=1 twice exp idle between", name, n);
        end
        checks++;
        if (bus_q.size() == 0) begin
          failures++;
          $display("FAIL %0s_extra_strobe n=%0d got addr=%h wr=%b exp no access", name, n, m_addr, m_wr);
        end else begin
          e = bus_q.pop_front();
          if ({m_wr, m_rd, m_addr, m_wdata} !== {e.wr, ~e.wr, e.addr, e.data}) begin
            failures++;
            $display("FAIL %0s_bus n=%0d got wr=%b rd=%b addr=%h wdata=%h exp wr=%b addr=%h wdata=%h",
                     name, n, m_wr, m_rd, m_addr, m_wdata, e.wr, e.addr, e.data);
          end
        end
        checks++;
        if (n != (last_n == 0 ? 1 : last_n + (last_rd ? 3 : 2))) begin
          failures++;
          $display("FAIL %0s_spacing got n=%0d after prev=%0d rd=%b", name, n, last_n, last_rd);
        end
        last_n = n;
        last_rd = m_rd;
      end else begin
        checks++;
        if ({m_rd, m_wr, m_addr, m_wdata} !== 23'h0) begin
          failures++;
          $display("FAIL %0s_idle_bus n=%0d got rd=%b wr=%b addr=%h wdata=%h exp all 0",
                   name, n, m_rd, m_wr, m_addr, m_wdata);
        end
      end
      prev_cs = m_cs;
      if (m_resp_valid) begin
        got = 1'b1;
        exp_r = resp_q.pop_front();
        checks++;
        if ({m_resp_err, m_resp_data} !== exp_r) begin
          failures++;
          $display("FAIL %0s_resp got err=%b data=%h exp err=%b data=%h",
                   name, m_resp_err, m_resp_data, exp_r[32], exp_r[31:0]);
        end
        checks++;
        if (n - 1 != exp_lat) begin
          failures++;
          $display("FAIL %0s_latency got=%0d exp=%0d", name, n - 1, exp_lat);
        end
      end else begin
        checks++;
        if (m_ready !== 1'b0) begin
          failures++;
          $display("FAIL %0s_ready_busy n=%0d got=%b exp=0", name, n, m_ready);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %0s_no_resp got none within 300 cycles exp resp_valid", name);
      resp_q.delete();
    end
    checks++;
    if (bus_q.size() != 0) begin
      failures++;
      $display("FAIL %0s_missing_strobes got %0d unconsumed exp 0", name, bus_q.size());
    end
    bus_q.delete();
    if (!hold && got) begin
      @(negedge clk);
      checks++;
      if ({m_resp_valid, m_ready, m_resp_err, m_resp_data} !== {1'b0, 1'b1, exp_r}) begin
        failures++;
        $display("FAIL %0s_after_resp got valid=%b ready=%b err=%b data=%h exp valid=0 ready=1 err=%b data=%h",
                 name, m_resp_valid, m_ready, m_resp_err, m_resp_data, exp_r[32], exp_r[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs0, rd0, wr0, addr0, wdata0, resp_valid0, resp_err0, resp_data0, req_ready0} !== {57'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_dut0 got cs=%b rd=%b wr=%b addr=%h wdata=%h v=%b err=%b data=%h rdy=%b exp zeros rdy=1",
               cs0, rd0, wr0, addr0, wdata0, resp_valid0, resp_err0, resp_data0, req_ready0);
    end
    checks++;
    if ({cs1, rd1, wr1, addr1, wdata1, resp_valid1, resp_err1, resp_data1, req_ready1} !== {57'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_dut1 got cs=%b addr=%h v=%b err=%b data=%h rdy=%b exp zeros rdy=1",
               cs1, addr1, resp_valid1, resp_err1, resp_data1, req_ready1);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready0, cs0, req_ready1, cs1} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_release got rdy0=%b cs0=%b rdy1=%b cs1=%b exp 1 0 1 0",
               req_ready0, cs0, req_ready1, cs1);
    end
  endtask

  task automatic test_single_poll();
    run_txn("s1", 1'b0, 16'h0020, 16'h000F, 1, 1'b0, 1'b0, 0, 11);
    run_txn("s1b", 1'b0, 16'hFFFF, 16'h0001, 1, 1'b0, 1'b0, 0, 11);
  endtask

  task automatic test_multi_poll();
    run_txn("s2", 1'b0, 16'h1234, 16'h0056, 5, 1'b0, 1'b0, 0, 23);
  endtask

  task automatic test_timeout();
    run_txn("s3", 1'b1, 16'h00A5, 16'h0003, 4, 1'b1, 1'b0, 0, 17);
  endtask

  task automatic test_reset_abort();
    bit   found;
    logic prev_poll;
    int   bad;
    sel = 1'b0;
    done_target = 0;
    @(negedge clk);
    op_a = 16'h0042;
    op_b = 16'h0007;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    found = 1'b0;
    prev_poll = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (prev_poll) found = 1'b1;
      else prev_poll = m_cs && m_rd && (m_addr == REG_DONE);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL s4_reach_poll_wait got no poll within 60 cycles exp poll");
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cs0, req_ready0, resp_valid0} !== 3'b010) begin
      failures++;
      $display("FAIL s4_abort got cs=%b ready=%b resp_valid=%b exp 0 1 0", cs0, req_ready0, resp_valid0);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cs0 || resp_valid0 || !req_ready0 || resp_err0 || resp_data0 != 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL s4_quiet got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("s5a", 1'b0, 16'h0300, 16'h0010, 1, 1'b0, 1'b1, 0, 11);
    run_txn("s5b", 1'b0, 16'h0BEE, 16'h0022, 1, 1'b0, 1'b0, 0, 11);
  endtask

  task automatic test_ignored_pulse();
    int extra;
    run_txn("s6", 1'b0, 16'h7777, 16'h0011, 2, 1'b0, 1'b0, 5, 14);
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cs0 || resp_valid0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL s6_no_second_txn got %0d active cycles exp 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_single_poll();
    test_multi_poll();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    test_ignored_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_bus_master.md
DIV_BUS_MASTER -- requirements
Module: div_bus_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and reset.
REQ-002 Parameter POLL_MAX, default 64, SHALL set the maximum number of done-polls before timeout.
REQ-003 Parameter GAP, default 1, SHALL set the number of idle bus cycles between consecutive accesses.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  block idle and accepting a request.
- op_a  in  16  dividend.
- op_b  in  16  divisor.
- resp_valid  out  1  result available, single-cycle pulse.
- resp_data  out  32  raw word read from the peripheral data register.
- resp_err  out  1  poll timeout occurred; qualified by resp_valid.
- cs  out  1  peripheral chip select.
- rd  out  1  peripheral read strobe.
- wr  out  1  peripheral write strobe.
- addr  out  5  peripheral register address.
- wdata  out  16  write data, connected to the peripheral d_in.
- rdata  in  32  peripheral d_out.

Function
REQ-005 The register map SHALL be: 0x04 operand A, 0x08 operand B, 0x0C init (write 0x0001), 0x10 result (read), 0x14 done (read, bit 0).
REQ-006 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; op_a and op_b SHALL be latched on that cycle.
REQ-007 req_ready SHALL be 1 only in state IDLE.
REQ-008 The FSM states SHALL be IDLE, WR_A, WR_B, WR_INIT, POLL, POLL_WAIT, RD, RD_WAIT, RESP and GAP. GAP is a shared idle state with a return-target register and a counter.
REQ-009 The state sequence SHALL be: IDLE -> WR_A -> GAP -> WR_B -> GAP -> WR_INIT -> GAP -> POLL -> POLL_WAIT.
- From POLL_WAIT: rdata[0]=1 -> GAP -> RD; rdata[0]=0 -> GAP -> POLL.
- RD -> RD_WAIT -> RESP -> IDLE.
REQ-010 Each WR_*, POLL or RD state SHALL last exactly one cycle with cs=1. Every other state SHALL drive cs=rd=wr=0.
REQ-011 Write states SHALL drive wr=1, rd=0 and the matching addr/wdata: op_a, op_b, 16'h0001.
REQ-012 POLL and RD SHALL drive rd=1, wr=0 and addr 0x14 or 0x10 respectively.
REQ-013 rdata SHALL be sampled at the end of the cycle after the rd strobe (POLL_WAIT, RD_WAIT).
REQ-014 GAP SHALL last exactly GAP cycles. With GAP=0 it is bypassed.
REQ-015 Address and data outputs SHALL be 0 whenever cs=0.
REQ-016 Poll counter behaviour:
- cleared on request acceptance.
- incremented in each POLL state.
- when POLL_WAIT sees done=0 with the count equal to POLL_MAX, the FSM SHALL go to RESP with resp_err=1 and resp_data=0, skipping RD.
REQ-017 RESP SHALL assert resp_valid for exactly one cycle. resp_data and resp_err SHALL hold their values until the next acceptance.
REQ-018 With GAP=1 and done seen on the first poll, latency from acceptance to resp_valid SHALL be 11 cycles.
REQ-019 req_valid asserted outside IDLE SHALL be ignored; no queuing.

Reset
REQ-020 While reset=0 at a rising edge, the block SHALL enter IDLE and clear the GAP counter, poll counter and latched operands.
REQ-021 Output reset values SHALL be: cs=rd=wr=0, addr=0, wdata=0, resp_valid=0, resp_err=0, resp_data=0, req_ready=1 from the first cycle after reset release.
REQ-022 Reset asserted mid-sequence SHALL abort the sequence with no further bus strobes and no resp_valid.

Structure
REQ-023 The register offsets (0x04, 0x08, 0x0C, 0x10, 0x14), the init value and the state encoding SHALL live in a shared package/include (div_regs) used by both peripheral_div and this block.
REQ-024 The block SHALL be a single module with no sub-modules. The GAP counter and the poll counter SHALL be inline registers.

Verification
REQ-025 The bench SHALL use a peripheral_div instance or a behavioural stub, and SHALL cover the following scenarios:
- Scenario 1: op_a=0x0020, op_b=0x000F, stub done on the first poll -> bus writes (0x04,0x0020), (0x08,0x000F), (0x0C,0x0001), then reads 0x14, 0x10; resp_valid 11 cycles after acceptance; resp_data equals the stub value 0x0002_0002; resp_err=0.
- Scenario 2: stub done after 5 polls -> exactly 5 reads of 0x14, each separated by GAP idle cycles, then one read of 0x10.
- Scenario 3: stub never done, POLL_MAX=4 -> 4 polls, resp_err=1, resp_data=0, no read of 0x10.
- Scenario 4: reset=0 asserted during POLL_WAIT -> next cycle cs=0, req_ready=1, no resp_valid.
- Scenario 5: req_valid held high throughout -> second request accepted only on the cycle after RESP; cs never asserted on two consecutive cycles when GAP=1.
- Scenario 6: req_valid pulsed mid-sequence -> ignored; no second transaction.
